mod_product: RTL

MOD_PRODUCT -- requirements
Module: mod_product

---
 rtl/rsa_pkg.sv | 6 +
 rtl/mod_product.sv | 65 ++++++
 2 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: key width, counter width and FSM state shared by the RSA datapath stages.
package rsa_pkg;
    localparam int KEY_W = 256;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
endpackage

// File: rtl/mod_product.sv
// mod_product: computes a * 2^KEY_W mod N by KEY_W iterated double-and-conditional-subtract steps.
module mod_product #(
    parameter int KEY_W = rsa_pkg::KEY_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_n,
    input  logic [KEY_W-1:0] i_a,
    output logic [KEY_W-1:0] o_result,
    output logic             o_finished
);
    import rsa_pkg::*;

    state_t             r_state, w_state_nx;
    logic [KEY_W:0]     r_t, w_t_nx, w_d, w_n_ext;
    logic [KEY_W-1:0]   r_n, w_n_nx, w_res_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic               w_start, w_calc, w_done, w_last;

    assign w_start = (r_state == S_IDLE) && i_start;
    assign w_calc  = (r_state == S_CALC);
    assign w_done  = (r_state == S_DONE);
    assign w_last  = r_cnt == CNT_W'(KEY_W - 1);
    // t is kept one bit wider so 2*t cannot overflow even when N = 2^KEY_W-1
    assign w_d     = {r_t[KEY_W-1:0], 1'b0};
    assign w_n_ext = {1'b0, r_n};

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  w_state_nx = i_start ? S_CALC : S_IDLE;
            S_CALC:  w_state_nx = w_last ? S_DONE : S_CALC;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_n_nx   = w_start ? i_n : r_n;
        w_t_nx   = w_start ? {1'b0, i_a}
                 : w_calc  ? ((w_d >= w_n_ext) ? w_d - w_n_ext : w_d)
                 : r_t;
        w_cnt_nx = w_start ? '0 : w_calc ? r_cnt + 1'b1 : r_cnt;
        w_res_nx = w_done ? r_t[KEY_W-1:0] : o_result;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_n        <= '0;
            r_cnt      <= '0;
            o_result   <= '0;
            o_finished <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_t        <= w_t_nx;
            r_n        <= w_n_nx;
            r_cnt      <= w_cnt_nx;
            o_result   <= w_res_nx;
            o_finished <= w_done;
        end
    end
endmodule
